// File: rtl/hack_mem_ctrl.sv
// rtl/hack_mem_ctrl.sv - Hack CPU memory controller: RAM, keyboard and unmapped decode
// Optional err output enabled by defining HACK_MEM_CTRL_ERR_EN.
module hack_mem_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [0:14] cpu_addr,
   input  logic [0:15] cpu_wdata,
   output logic [0:15] cpu_rdata,
   output logic        cpu_ready,
   output logic [0:12] ram_address,
   output logic [0:15] ram_data,
   output logic        ram_load,
   input  logic [0:15] ram_out,
   input  logic [0:15] kbd_code
`ifdef HACK_MEM_CTRL_ERR_EN
   ,
   output logic        err
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state, state_nxt;
   logic [0:14] addr_q;
   logic        we_q;
   logic [0:15] wdata_q;
   logic        is_ram;
   logic        is_kbd;

   assign is_ram = (addr_q[0:1] == 2'b00);
   assign is_kbd = (addr_q == 15'h6000);

   // The captured registers feed the RAM port directly, so the address holds between accesses.
   assign ram_address = addr_q[2:14];
   assign ram_data    = wdata_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         addr_q    <= '0;
         we_q      <= 1'b0;
         wdata_q   <= '0;
         cpu_rdata <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
         end
         if (state == ISSUE && !we_q && !is_ram)
            cpu_rdata <= is_kbd ? kbd_code : 16'h0000;
         if (state == WAIT)
            cpu_rdata <= ram_out;
      end
   end

   always_comb begin
      state_nxt = state;
      ram_load  = 1'b0;
      cpu_ready = 1'b0;
      case (state)
         IDLE:  if (cpu_req) state_nxt = ISSUE;
         ISSUE: begin
            // Gated by reset so an aborted access never commits a write.
            ram_load  = we_q && is_ram && !reset;
            state_nxt = (is_ram && !we_q) ? WAIT : DONE;
         end
         WAIT:  state_nxt = DONE;
         DONE:  begin
            cpu_ready = !reset;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef HACK_MEM_CTRL_ERR_EN
   assign err = cpu_ready && !is_ram && (!is_kbd || we_q);
`endif

endmodule

// File: tb/tb_hack_mem_ctrl.sv
// tb/tb_hack_mem_ctrl.sv - scoreboard bench for hack_mem_ctrl with a behavioural 8K RAM
module tb_hack_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [14:0] cpu_addr = '0;
   logic [15:0] cpu_wdata = '0;
   logic [15:0] cpu_rdata;
   logic        cpu_ready;
   logic [12:0] ram_address;
   logic [15:0] ram_data;
   logic        ram_load;
   logic [15:0] ram_out = '0;
   logic [15:0] kbd_code = '0;
`ifdef HACK_MEM_CTRL_ERR_EN
   logic        err;
`endif

   typedef struct {
      logic [15:0] rdata;
      int          lat;
      logic        wr;
      logic [12:0] waddr;
      logic [15:0] wdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] mem       [0:8191];
   logic [15:0] model_mem [0:8191];
   logic [15:0] model_rdata = '0;
   int          vectors = 0;
   int          miscompares = 0;

   hack_mem_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ready   (cpu_ready),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_load    (ram_load),
      .ram_out     (ram_out),
      .kbd_code    (kbd_code)
`ifdef HACK_MEM_CTRL_ERR_EN
      ,
      .err         (err)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_load) mem[ram_address] <= ram_data;
      ram_out <= mem[ram_address];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic access(input logic we, input logic [14:0] addr, input logic [15:0] wd, input string tag);
      exp_t        e, got;
      int          n, wr_cnt;
      logic [12:0] wa;
      logic [15:0] wdv;
      logic        is_ram, is_kbd, err_seen;
      is_ram = (addr[14:13] == 2'b00);
      is_kbd = (addr == 15'h6000);
      if (we) begin
         if (is_ram) model_mem[addr[12:0]] = wd;
      end else if (is_ram) model_rdata = model_mem[addr[12:0]];
      else if (is_kbd)     model_rdata = kbd_code;
      else                 model_rdata = 16'h0000;
      e.rdata = model_rdata;
      e.lat   = (!we && is_ram) ? 3 : 2;
      e.wr    = we && is_ram;
      e.waddr = addr[12:0];
      e.wdata = wd;
      e.err   = !is_ram && (!is_kbd || we);
      sb.push_back(e);

      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      @(posedge clk); #1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'($urandom); cpu_wdata = 16'($urandom);

      n = 0; wr_cnt = 0; wa = '0; wdv = '0; err_seen = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (ram_load) begin
            wr_cnt++; wa = ram_address; wdv = ram_data;
         end
         if (cpu_ready) begin
`ifdef HACK_MEM_CTRL_ERR_EN
            err_seen = err;
`endif
            n = i;
            break;
         end
      end
      got = sb.pop_front();
      check({tag, " latency"}, n, got.lat);
      check({tag, " rdata"}, cpu_rdata, got.rdata);
      check({tag, " ram_load count"}, wr_cnt, got.wr ? 1 : 0);
      if (got.wr) begin
         check({tag, " ram_address"}, wa, got.waddr);
         check({tag, " ram_data"}, wdv, got.wdata);
      end
`ifdef HACK_MEM_CTRL_ERR_EN
      check({tag, " err"}, err_seen, got.err);
`else
      if (err_seen) check({tag, " err"}, err_seen, 1'b0);
`endif
      @(negedge clk);
      check({tag, " ready single pulse"}, cpu_ready, 1'b0);
      check({tag, " rdata held"}, cpu_rdata, got.rdata);
   endtask

   initial begin
      int pulse_at[3];
      int pulses, rdy_cnt;

      for (int i = 0; i < 8192; i++) begin
         mem[i] = '0;
         model_mem[i] = '0;
      end

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset cpu_rdata", cpu_rdata, 16'h0000);
      check("reset cpu_ready", cpu_ready, 1'b0);
      check("reset ram_load", ram_load, 1'b0);
      check("reset ram_address", ram_address, 13'h0000);
      check("reset ram_data", ram_data, 16'h0000);

      access(1'b1, 15'h0005, 16'hBEEF, "wr 0005");
      access(1'b0, 15'h0005, 16'h0000, "rd 0005");
      kbd_code = 16'h0041;
      access(1'b0, 15'h6000, 16'h0000, "kbd rd");
      access(1'b1, 15'h6000, 16'h1111, "kbd wr");
      access(1'b0, 15'h4010, 16'h0000, "unmapped rd 4010");
      access(1'b1, 15'h7FFF, 16'h2222, "unmapped wr 7FFF");
      access(1'b0, 15'h5FFF, 16'h0000, "unmapped rd 5FFF");
      access(1'b0, 15'h6001, 16'h0000, "unmapped rd 6001");
      access(1'b1, 15'h1FFF, 16'h1234, "wr 1FFF");
      access(1'b1, 15'h0000, 16'h5678, "wr 0000");
      access(1'b0, 15'h1FFF, 16'h0000, "rd 1FFF");
      access(1'b0, 15'h0000, 16'h0000, "rd 0000");
      access(1'b0, 15'h0005, 16'h0000, "rd 0005 again");

      // Held request: reads then writes, measuring the spacing of ready pulses.
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
      pulses = 0; pulse_at = '{0, 0, 0};
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (cpu_ready && pulses < 3) begin
            pulse_at[pulses] = c; pulses++;
         end
      end
      check("held rd pulses", pulses, 3);
      check("held rd spacing 1", pulse_at[1] - pulse_at[0], 4);
      check("held rd spacing 2", pulse_at[2] - pulse_at[1], 4);
      check("held rd data", cpu_rdata, 16'hBEEF);
      @(posedge clk); #1 cpu_req = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0006; cpu_wdata = 16'hCAFE;
      pulses = 0; pulse_at = '{0, 0, 0};
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (cpu_ready && pulses < 3) begin
            pulse_at[pulses] = c; pulses++;
         end
      end
      check("held wr pulses", pulses, 3);
      check("held wr spacing 1", pulse_at[1] - pulse_at[0], 3);
      check("held wr spacing 2", pulse_at[2] - pulse_at[1], 3);
      @(posedge clk); #1 cpu_req = 1'b0;
      repeat (5) @(posedge clk);
      model_mem[6] = 16'hCAFE;
      model_rdata  = 16'hBEEF;
      access(1'b0, 15'h0006, 16'h0000, "rd 0006 after held wr");

      // Reset asserted during the WAIT cycle of a RAM read.
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0005;
      @(posedge clk); #1 cpu_req = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      rdy_cnt = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (cpu_ready) rdy_cnt++;
      end
      check("abort ready count", rdy_cnt, 0);
      check("abort cpu_rdata", cpu_rdata, 16'h0000);
      model_rdata = 16'h0000;
      access(1'b0, 15'h1FFF, 16'h0000, "rd 1FFF after abort");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
